// File: rtl/ysyx_23060201_dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, byte-mask helper.
package ysyx_23060201_dmem_ctrl_pkg;

  localparam logic [1:0] SIZE_B   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_W   = 2'd2;
  localparam logic [1:0] SIZE_ILL = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Unshifted byte-enable pattern for an access size; illegal size enables nothing.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060201_dmem_ctrl_if.sv
// LSU <-> data-memory request/response channel; master is the LSU, slave is the controller.
interface ysyx_23060201_dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_23060201_dmem_ctrl_mem_align.sv
// Combinational lane logic: store byte-mask and lane shift, load extract with sign/zero extension,
// and the misalignment / illegal-size flag.
module ysyx_23060201_mem_align
  import ysyx_23060201_dmem_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign wmask      = size_mask(size) << off;
  assign wdata_lane = wdata << {off, 3'b000};
  assign shifted    = raw >> {off, 3'b000};
  assign misaligned = (size == SIZE_ILL)
                   || (size == SIZE_H && off[0])
                   || (size == SIZE_W && off != 2'b00);

  always_comb begin
    load_data = '0;
    case (size)
      SIZE_B:  load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SIZE_W:  load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_dmem_ctrl.sv
// Data-memory controller: one request at a time, LATENCY-cycle access, held response.
// The memory backend is an internal word array with byte-enable writes and a range check.
module ysyx_23060201_dmem_ctrl
  import ysyx_23060201_dmem_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    LATENCY     = 1,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000)
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_23060201_dmem_ctrl_if.slave bus
);

  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  logic [1:0]            state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  wen_q;
  logic                  uns_q;
  logic                  err_q;
  logic [31:0]           raw_q;

  logic        accept;
  logic        exec;
  logic        resp;
  logic        req_err;
  logic        misaligned;
  logic        out_of_range;
  logic [3:0]  wmask;
  logic [31:0] wdata_lane;
  logic [31:0] load_data;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign accept        = bus.req_valid && (state_q == ST_IDLE);
  assign exec          = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign resp          = (state_q == ST_RESP);
  assign req_err       = misaligned || out_of_range;

  assign bus.rsp_valid = resp;
  assign bus.rsp_err   = resp && err_q;
  assign bus.rsp_rdata = (resp && !err_q && !wen_q) ? load_data : 32'h0;

  ysyx_23060201_mem_align u_align (
    .off        (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .wdata      (wdata_q),
    .raw        (raw_q),
    .wmask      (wmask),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // The request is captured at accept so later bus activity cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= SIZE_B;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= LAT_INIT;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            wen_q   <= bus.req_wen;
            uns_q   <= bus.req_unsigned;
            err_q   <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            err_q   <= req_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-3:0] word_off;
  logic [IDX_W-1:0]      mem_idx;

  // Subtraction wraps addresses below BASE_ADDR to large offsets, so one compare covers both ends.
  assign word_off     = addr_q[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign out_of_range = (word_off >= (ADDR_WIDTH-2)'(DEPTH_WORDS));
  assign mem_idx      = word_off[IDX_W-1:0];

  // The single memory access of a request happens on the BUSY->RESP edge, never on error.
  always_ff @(posedge clk) begin
    if (exec && !req_err) begin
      if (wen_q) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mem[mem_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end else begin
        raw_q <= mem[mem_idx];
      end
    end
  end

endmodule
